// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - streams one convolution frame of pixel words into the accelerator FIFO
// A single hold register decouples upstream from FIFO backpressure; each frame ends with one zero flush word.
module conv_window_feeder #(
    parameter int bitLength = 16,
    parameter int ROW_WORDS = 6,
    parameter int ROWS      = 3,
    localparam int TOTAL    = ROWS * ROW_WORDS,
    localparam int CW       = $clog2(TOTAL + 2)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [bitLength-1:0] src_data,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic                 FULL,
    output logic                 wr_en,
    output logic [bitLength-1:0] dataInput,
    output logic                 cStart,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        words_sent
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSTART,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] TOTAL_W = CW'(TOTAL);

    state_t               r_state;
    logic [bitLength-1:0] r_hold_data;
    logic                 r_hold_valid;
    logic [CW-1:0]        r_accepted;
    logic [CW-1:0]        r_words_sent;
    logic                 r_cstart;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_load;
    logic                 w_hold_valid_nxt;
    logic [CW-1:0]        w_accepted_nxt;

    // Handshakes stay combinational so a full FIFO stalls in the same cycle it rises.
    always_comb begin
        src_ready = 1'b0;
        wr_en     = 1'b0;
        dataInput = '0;
        case (r_state)
            S_STREAM: begin
                src_ready = (r_accepted < TOTAL_W) && (!r_hold_valid || !FULL);
                wr_en     = r_hold_valid && !FULL && !abort;
                dataInput = r_hold_data;
            end
            S_FLUSH: begin
                wr_en = !FULL && !abort;
            end
            default: ;
        endcase
    end

    assign w_load           = src_valid && src_ready;
    assign w_hold_valid_nxt = w_load || (r_hold_valid && !wr_en);
    assign w_accepted_nxt   = r_accepted + CW'(w_load);

    assign cStart     = r_cstart;
    assign busy       = r_busy;
    assign done       = r_done;
    assign words_sent = r_words_sent;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_hold_data  <= '0;
            r_hold_valid <= 1'b0;
            r_accepted   <= '0;
            r_words_sent <= '0;
            r_cstart     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (abort) begin
            r_state      <= S_IDLE;
            r_hold_valid <= 1'b0;
            r_accepted   <= '0;
            r_words_sent <= '0;
            r_cstart     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_cstart <= 1'b0;
            r_done   <= 1'b0;
            if (wr_en) begin
                r_words_sent <= r_words_sent + 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_CSTART;
                        r_hold_valid <= 1'b0;
                        r_accepted   <= '0;
                        r_words_sent <= '0;
                        r_cstart     <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_CSTART: begin
                    r_state <= S_STREAM;
                end
                S_STREAM: begin
                    r_hold_valid <= w_hold_valid_nxt;
                    r_accepted   <= w_accepted_nxt;
                    if (w_load) begin
                        r_hold_data <= src_data;
                    end
                    // Leave on the edge that drains the last word so the flush write follows back to back.
                    if (!w_hold_valid_nxt && (w_accepted_nxt == TOTAL_W)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (wr_en) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - randomized scoreboard bench for conv_window_feeder
module tb_conv_window_feeder;

    localparam int BL    = 16;
    localparam int RW    = 6;
    localparam int RS    = 3;
    localparam int TOTAL = RW * RS;
    localparam int CW    = $clog2(TOTAL + 2);

    logic          Clk = 1'b0;
    logic          Rst;
    logic          start;
    logic          abort;
    logic [BL-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          FULL;
    logic          wr_en;
    logic [BL-1:0] dataInput;
    logic          cStart;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_sent;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    conv_window_feeder #(
        .bitLength(BL),
        .ROW_WORDS(RW),
        .ROWS     (RS)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .abort     (abort),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .FULL      (FULL),
        .wr_en     (wr_en),
        .dataInput (dataInput),
        .cStart    (cStart),
        .busy      (busy),
        .done      (done),
        .words_sent(words_sent)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_src_ready"}, src_ready, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_data"}, dataInput, 0);
        check({tag, "_cstart"}, cStart, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // pv: percent valid (-1 = alternate), pf: percent FULL, abort_at: abort once this many words accepted
    task automatic run_frame(input int pv, input int pf, input int abort_at, input bit bp,
                             input bit busy_start, input bit rst_flush, input bit seq);
        int q[$];
        int n_acc, n_wr, bp_cnt, first_wr, done_cyc;
        bit got_done;
        n_acc = 0; n_wr = 0; bp_cnt = 0; first_wr = -1; done_cyc = -1; got_done = 0;

        @(posedge Clk); #1;
        start = 1; abort = 0; src_valid = 0; FULL = 0;
        @(posedge Clk); #1;
        start = 0;
        #2;
        check("cstart_pulse", cStart, 1);
        check("cstart_busy", busy, 1);
        check("cstart_ws_clear", words_sent, 0);
        check("cstart_no_wr", wr_en, 0);

        for (int cyc = 0; cyc < 400 && !got_done; cyc++) begin
            @(posedge Clk); #1;
            src_valid = (pv < 0) ? ((cyc % 2) == 0) : ($urandom_range(99) < pv);
            src_data  = seq ? BL'(n_acc + 1) : BL'($urandom);
            if (bp && n_wr == 4 && bp_cnt < 5) begin
                FULL = 1;
                bp_cnt++;
            end else begin
                FULL = ($urandom_range(99) < pf);
            end
            start = busy_start && (cyc == 3 || cyc == 9);
            abort = (abort_at >= 0) && (n_acc == abort_at);
            if (rst_flush && n_acc == TOTAL && q.size() == 0) FULL = 1;
            #2;

            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                check("done_words_sent", words_sent, TOTAL + 1);
                check("done_write_count", n_wr, TOTAL + 1);
                check("done_busy", busy, 0);
                check("done_queue_empty", q.size(), 0);
                check("done_no_wr", wr_en, 0);
            end else begin
                check("stream_busy", busy, 1);
                check("stream_cstart", cStart, 0);
                check("words_sent_track", words_sent, n_wr);
                if (FULL) check("wr_while_full", wr_en, 0);
                if (abort) check("wr_on_abort", wr_en, 0);
                if (FULL && q.size() > 0) check("no_overwrite", src_ready, 0);
                if (wr_en) begin
                    if (first_wr < 0) first_wr = cyc;
                    if (q.size() > 0) begin
                        check("write_data", dataInput, q.pop_front());
                    end else begin
                        check("flush_data", dataInput, 0);
                        check("flush_after_all", n_acc, TOTAL);
                    end
                    n_wr++;
                end
                if (src_valid && src_ready) begin
                    check("accept_bound", n_acc < TOTAL, 1);
                    q.push_back(int'(src_data));
                    n_acc++;
                end

                if (rst_flush && n_acc == TOTAL && q.size() == 0 && FULL) begin
                    check("flush_stalled", wr_en, 0);
                    #1;
                    Rst = 1;
                    #1;
                    check_quiet("async_rst");
                    check("async_rst_ws", words_sent, 0);
                    @(posedge Clk); #1;
                    Rst = 0; FULL = 0; src_valid = 1;
                    #2;
                    check_quiet("post_rst");
                    repeat (4) begin
                        @(posedge Clk); #3;
                        check("post_rst_idle_busy", busy, 0);
                        check("post_rst_idle_wr", wr_en, 0);
                    end
                    src_valid = 0;
                    return;
                end

                if (abort) begin
                    @(posedge Clk); #1;
                    abort = 0; src_valid = 1;
                    #2;
                    check_quiet("post_abort");
                    check("post_abort_ws", words_sent, 0);
                    repeat (5) begin
                        @(posedge Clk); #3;
                        check("abort_no_wr", wr_en, 0);
                        check("abort_no_done", done, 0);
                    end
                    src_valid = 0;
                    return;
                end
            end
        end

        if (!got_done) check("frame_timeout", 0, 1);
        if (seq && !bp && pv == 100 && pf == 0) begin
            check("first_write_latency", first_wr, 1);
            check("done_cycle", done_cyc, TOTAL + 2);
        end
        src_valid = 0; start = 0; FULL = 0;
        @(posedge Clk); #3;
        check("after_done_busy", busy, 0);
        check("after_done_pulse", done, 0);
    endtask

    initial begin
        Rst = 1; start = 0; abort = 0; src_valid = 0; src_data = 0; FULL = 0;
        #3;
        check_quiet("reset");
        check("reset_ws", words_sent, 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 0;

        @(posedge Clk); #1;
        start = 1; abort = 1;
        @(posedge Clk); #1;
        start = 0; abort = 0;
        #2;
        check("start_abort_busy", busy, 0);
        check("start_abort_cstart", cStart, 0);
        @(posedge Clk); #3;
        check("start_abort_stay_idle", busy, 0);

        run_frame(100, 0, -1, 0, 0, 0, 1);
        run_frame(100, 0, -1, 1, 0, 0, 1);
        run_frame(-1, 0, -1, 0, 0, 0, 1);
        run_frame(100, 0, 10, 0, 0, 0, 1);
        run_frame(100, 0, -1, 0, 0, 0, 1);
        run_frame(70, 30, -1, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            run_frame(40 + 15 * i, 10 * i, -1, 0, 0, 0, 0);
        end
        run_frame(60, 40, $urandom_range(1, TOTAL - 1), 0, 0, 0, 0);
        run_frame(100, 0, -1, 0, 0, 1, 1);
        run_frame(100, 0, -1, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_window_feeder.md
CONV_WINDOW_FEEDER -- requirements
Module: conv_window_feeder

Interface
REQ-001 SHALL have parameter bitLength, default 16, giving the data word width.
REQ-002 SHALL have parameter ROW_WORDS, default 6, giving the words per image row.
REQ-003 SHALL have parameter ROWS, default 3, giving the rows per convolution frame; TOTAL = ROWS*ROW_WORDS.
REQ-004 SHALL have port Clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request to begin a frame.
REQ-007 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-008 SHALL have port src_data, input, bitLength bits: upstream pixel word.
REQ-009 SHALL have port src_valid, input, 1 bit: upstream word valid.
REQ-010 SHALL have port src_ready, output, 1 bit: feeder accepts the word this cycle.
REQ-011 SHALL have port FULL, input, 1 bit: the accelerator input FIFO is full.
REQ-012 SHALL have port wr_en, output, 1 bit: write strobe into the accelerator FIFO.
REQ-013 SHALL have port dataInput, output, bitLength bits: word written when wr_en=1.
REQ-014 SHALL have port cStart, output, 1 bit: one-cycle convolution start pulse to the accelerator.
REQ-015 SHALL have port busy, output, 1 bit: the frame is in progress.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-017 SHALL have port words_sent, output, clog2(TOTAL+2) bits: count of FIFO writes in the current frame.

Function
REQ-018 SHALL implement the FSM IDLE -> CSTART -> STREAM -> FLUSH -> DONE -> IDLE.
REQ-019 IDLE: start=1 SHALL move the FSM to CSTART on the next edge and clear words_sent; start in any other state SHALL be ignored.
REQ-020 CSTART SHALL last exactly one cycle, with cStart=1 only in this state; the FSM then SHALL enter STREAM.
REQ-021 SHALL hold one word in a 1-entry hold register (hold_data, hold_valid).
REQ-022 In STREAM, src_ready SHALL equal (accepted<TOTAL) && (!hold_valid || !FULL), combinationally.
REQ-023 An upstream transfer SHALL occur on src_valid && src_ready; the word SHALL load into the hold register and increment accepted.
REQ-024 wr_en SHALL equal hold_valid && !FULL in STREAM; dataInput SHALL equal hold_data.
REQ-025 A write and a load in the same cycle SHALL replace the hold contents, with hold_valid staying 1; a write with no load SHALL clear hold_valid.
REQ-026 A word accepted in cycle N SHALL be written no earlier than cycle N+1; sustained throughput SHALL be 1 word/cycle while FULL=0.
REQ-027 When accepted==TOTAL and hold_valid=0, STREAM SHALL move to FLUSH.
REQ-028 FLUSH SHALL drive dataInput=0 and wr_en=!FULL; on the write, the FSM SHALL move to DONE.
REQ-029 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-030 words_sent SHALL increment on every wr_en=1; at DONE it SHALL equal TOTAL+1.
REQ-031 busy SHALL be 1 in CSTART, STREAM, and FLUSH, and 0 otherwise.
REQ-032 src_ready and wr_en SHALL be 0 outside STREAM and FLUSH; src_valid SHALL be ignored outside STREAM.
REQ-033 FULL=1 SHALL stall writes without losing or duplicating a word; the held word SHALL be written on the first cycle FULL=0.
REQ-034 abort=1 in any state SHALL, on the next edge, clear hold_valid and the counters and enter IDLE without a done pulse; abort SHALL take priority over start.
REQ-035 wr_en SHALL be 0 in the cycle abort is sampled.

Reset
REQ-036 Rst=1 SHALL asynchronously force IDLE, hold_valid=0, accepted=0, and words_sent=0.
REQ-037 While Rst=1, the outputs SHALL be src_ready=0, wr_en=0, dataInput=0, cStart=0, busy=0, and done=0.
REQ-038 Rst asserted mid-frame SHALL discard all in-flight data; the first frame after release SHALL require a new start.

Verification
REQ-039 Basic frame: start with src_valid always 1, words 1..18, FULL=0 -> cStart one cycle after start; 19 writes on consecutive cycles, 1..18 then 0; done one cycle later; words_sent=19.
REQ-040 Backpressure: FULL=1 for 5 cycles after the 4th write -> wr_en=0 while FULL=1; word 5 held then written; order preserved; no duplicates.
REQ-041 Upstream gaps: src_valid toggling 1/0 -> a write follows each accepted word; the flush zero comes only after word 18 is written.
REQ-042 Abort after word 10 accepted -> IDLE next edge; no further writes; done stays 0; a new start yields a full 19-write frame.
REQ-043 Async reset mid-FLUSH with FULL=1 -> all outputs 0 immediately, without waiting for a clock edge; no flush write occurs.
REQ-044 start while busy, and start coincident with abort -> ignored; the frame write count is unchanged, or the FSM stays IDLE respectively.
